// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction memory request/response, downstream redirect
// and the decode-side output stream.
interface inst_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc, out_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time, responses queued
// in a 2-entry buffer toward decode, with redirect flush and fault halting.
module inst_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam logic [1:0] LP_DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {StReq, StWait, StDrain, StFault} state_e;

  state_e      r_state, w_state_next;
  logic [63:0] r_fetch_pc, w_fetch_pc_next;
  logic [63:0] r_req_addr, w_req_addr_next;

  logic [31:0] r_buf_inst  [2];
  logic [63:0] r_buf_pc    [2];
  logic        r_buf_fault [2];
  logic        r_rd_ptr, r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;
  logic [63:0] w_redirect_target;

  // Request and output strobes; both are held low while reset is asserted
  assign bus.imem_req_valid = !rst && (r_state == StReq) && (r_count < LP_DEPTH);
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = !rst && (r_count != 2'd0);
  assign bus.out_inst       = r_buf_inst[r_rd_ptr];
  assign bus.out_pc         = r_buf_pc[r_rd_ptr];
  assign bus.out_fault      = r_buf_fault[r_rd_ptr];

  assign w_req_fire        = bus.imem_req_valid && bus.imem_req_ready;
  // A response landing in a redirect cycle is stale and never enters the buffer
  assign w_push            = (r_state == StWait) && bus.imem_rsp_valid && !bus.redirect_valid;
  assign w_pop             = bus.out_valid && bus.out_ready;
  assign w_redirect_target = bus.redirect_pc & ~64'h3;

  // Next-state, fetch PC and outstanding-request address
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    if (w_req_fire) begin
      w_req_addr_next = r_fetch_pc;
      w_fetch_pc_next = r_fetch_pc + 64'd4;
    end
    if (bus.redirect_valid) begin
      w_fetch_pc_next = w_redirect_target;
      case (r_state)
        StReq:   w_state_next = w_req_fire ? StDrain : StReq;
        // An in-flight request must still be drained before issuing again
        StWait,
        StDrain: w_state_next = bus.imem_rsp_valid ? StReq : StDrain;
        default: w_state_next = StReq;
      endcase
    end else begin
      unique case (r_state)
        StReq: begin
          if (w_req_fire) w_state_next = StWait;
        end
        StWait: begin
          if (bus.imem_rsp_valid) w_state_next = bus.imem_rsp_err ? StFault : StReq;
        end
        StDrain: begin
          if (bus.imem_rsp_valid) w_state_next = StReq;
        end
        StFault: w_state_next = StFault;
        default: w_state_next = StReq;
      endcase
    end
  end

  // FSM and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StReq;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  // Buffer occupancy and pointers; a redirect empties the buffer outright
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Buffer payload storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_wr_ptr]  <= bus.imem_rsp_data;
      r_buf_pc[r_wr_ptr]    <= r_req_addr;
      r_buf_fault[r_wr_ptr] <= bus.imem_rsp_err;
    end
  end

  // Requests are only issued with a free slot, so a push into a full buffer is a bug
  assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == LP_DEPTH)));

endmodule
